// File: rtl/multi_clock_div_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : multi_clock_div_if
// Brief    : Per-channel enable/ratio requests and divided-clock status bus.
// Revision : 1.0 - initial release
// ============================================================================
interface multi_clock_div_if #(
    parameter int RATIO_WD = 8,
    parameter int N_CH     = 4
);
    logic [N_CH-1:0]          i_clk_en;
    logic [N_CH*RATIO_WD-1:0] i_div_ratio;
    logic [N_CH-1:0]          o_div_clk;
    logic [N_CH-1:0]          o_tick;
    logic [N_CH-1:0]          o_ratio_ack;

    modport master (
        output i_clk_en,
        output i_div_ratio,
        input  o_div_clk,
        input  o_tick,
        input  o_ratio_ack
    );

    modport slave (
        input  i_clk_en,
        input  i_div_ratio,
        output o_div_clk,
        output o_tick,
        output o_ratio_ack
    );
endinterface
`default_nettype wire

// File: rtl/multi_clock_div.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : multi_clock_div
// Brief    : N independent glitch-free integer clock dividers with ref bypass.
// Revision : 1.0 - initial release
// ============================================================================
module multi_clock_div #(
    parameter int RATIO_WD = 8,
    parameter int N_CH     = 4
) (
    input  wire logic        i_ref_clk,
    input  wire logic        i_rst,
    multi_clock_div_if.slave bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [N_CH-1:0] w_div_clk;
    logic [N_CH-1:0] w_tick;
    logic [N_CH-1:0] w_ack;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [0:0]          state_q, state_d;
        logic [RATIO_WD-1:0] ratio_q, ratio_d;
        logic [RATIO_WD-1:0] cnt_q, cnt_d;
        logic                q_q, q_d;
        logic                tick_q, tick_d;
        logic                ack_q, ack_d;

        logic [RATIO_WD-1:0] w_new_ratio;
        logic [RATIO_WD-1:0] w_half;
        logic [RATIO_WD-1:0] w_cnt_inc;
        logic                w_valid;
        logic                w_boundary;
        logic                w_clk_out;

        assign w_new_ratio = bus.i_div_ratio[c*RATIO_WD +: RATIO_WD];
        assign w_valid     = bus.i_clk_en[c] && (w_new_ratio >= RATIO_WD'(2));
        // ceil(R/2) as floor + lsb stays within RATIO_WD bits even for all-ones R
        assign w_half      = (ratio_q >> 1) + {{(RATIO_WD-1){1'b0}}, ratio_q[0]};
        assign w_cnt_inc   = cnt_q + RATIO_WD'(1);
        assign w_boundary  = (cnt_q == (ratio_q - RATIO_WD'(1)));

        always_ff @(posedge i_ref_clk or negedge i_rst) begin
            if (!i_rst) begin
                state_q <= S_IDLE;
                ratio_q <= '0;
                cnt_q   <= '0;
                q_q     <= 1'b0;
                tick_q  <= 1'b0;
                ack_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                ratio_q <= ratio_d;
                cnt_q   <= cnt_d;
                q_q     <= q_d;
                tick_q  <= tick_d;
                ack_q   <= ack_d;
            end
        end

        always_comb begin
            state_d = state_q;
            ratio_d = ratio_q;
            cnt_d   = cnt_q;
            q_d     = q_q;
            tick_d  = 1'b0;
            ack_d   = 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    q_d   = 1'b0;
                    if (w_valid) begin
                        state_d = S_RUN;
                        ratio_d = w_new_ratio;
                        q_d     = 1'b1;
                        tick_d  = 1'b1;
                        ack_d   = 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_boundary) begin
                        cnt_d = '0;
                        // Inputs are only looked at here, so a period is never cut short
                        if (w_valid) begin
                            ratio_d = w_new_ratio;
                            q_d     = 1'b1;
                            tick_d  = 1'b1;
                            ack_d   = (w_new_ratio != ratio_q);
                        end else begin
                            state_d = S_IDLE;
                            q_d     = 1'b0;
                        end
                    end else begin
                        cnt_d = w_cnt_inc;
                        q_d   = (w_cnt_inc < w_half);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        always_comb begin
            w_clk_out = (state_q == S_RUN) ? q_q : i_ref_clk;
        end

        assign w_div_clk[c] = w_clk_out;
        assign w_tick[c]    = tick_q;
        assign w_ack[c]     = ack_q;
    end

    assign bus.o_div_clk   = w_div_clk;
    assign bus.o_tick      = w_tick;
    assign bus.o_ratio_ack = w_ack;

endmodule
`default_nettype wire

// File: tb/tb_multi_clock_div.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_multi_clock_div
// Brief    : Directed self-checking bench for multi_clock_div.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_clock_div;

    localparam int RATIO_WD = 8;
    localparam int N_CH     = 4;

    logic i_ref_clk = 1'b0;
    logic i_rst;
    int   total = 0;
    int   bad   = 0;

    multi_clock_div_if #(.RATIO_WD(RATIO_WD), .N_CH(N_CH)) bus ();

    multi_clock_div #(.RATIO_WD(RATIO_WD), .N_CH(N_CH)) dut (
        .i_ref_clk (i_ref_clk),
        .i_rst     (i_rst),
        .bus       (bus.slave)
    );

    always #5 i_ref_clk = ~i_ref_clk;

    task automatic step();
        @(posedge i_ref_clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input bit en, input int ratio);
        bus.i_clk_en[ch] = en;
        bus.i_div_ratio[ch*RATIO_WD +: RATIO_WD] = RATIO_WD'(ratio);
    endtask

    function automatic logic [2:0] obs(input int ch);
        return {bus.o_div_clk[ch], bus.o_tick[ch], bus.o_ratio_ack[ch]};
    endfunction

    task automatic test_reset();
        i_rst           = 1'b0;
        bus.i_clk_en    = '0;
        bus.i_div_ratio = '0;
        set_ch(0, 1'b1, 4);
        repeat (3) step();
        total++;
        if (bus.o_tick !== 4'b0000 || bus.o_ratio_ack !== 4'b0000) begin
            bad++;
            $display("FAIL reset_pulses: tick=%b ack=%b want 0000/0000", bus.o_tick, bus.o_ratio_ack);
        end
        total++;
        if (bus.o_div_clk !== 4'b1111) begin
            bad++;
            $display("FAIL reset_bypass_hi: div_clk=%b want 1111", bus.o_div_clk);
        end
        @(negedge i_ref_clk);
        #1;
        total++;
        if (bus.o_div_clk !== 4'b0000) begin
            bad++;
            $display("FAIL reset_bypass_lo: div_clk=%b want 0000", bus.o_div_clk);
        end
        set_ch(0, 1'b0, 0);
        step();
        i_rst = 1'b1;
    endtask

    task automatic test_ratio4();
        logic [2:0] exp;
        int         acks;
        acks = 0;
        set_ch(0, 1'b1, 4);
        for (int t = 0; t < 16; t++) begin
            step();
            exp = {((t % 4) < 2), ((t % 4) == 0), (t == 0)};
            total++;
            if (obs(0) !== exp) begin
                bad++;
                $display("FAIL ratio4 cyc=%0d: clk/tick/ack=%b want %b", t, obs(0), exp);
            end
            acks += int'(bus.o_ratio_ack[0]);
        end
        total++;
        if (acks != 1) begin
            bad++;
            $display("FAIL ratio4_ack_count: got %0d want 1", acks);
        end
        set_ch(0, 1'b0, 4);
        step();
        total++;
        if (obs(0) !== 3'b100) begin
            bad++;
            $display("FAIL ratio4_to_bypass: clk/tick/ack=%b want 100", obs(0));
        end
        @(negedge i_ref_clk);
        #1;
        total++;
        if (bus.o_div_clk[0] !== 1'b0) begin
            bad++;
            $display("FAIL ratio4_bypass_lo: div_clk0=%b want 0", bus.o_div_clk[0]);
        end
    endtask

    task automatic test_ratio5();
        logic [2:0] exp;
        step();
        set_ch(1, 1'b1, 5);
        for (int t = 0; t < 50; t++) begin
            step();
            exp = {((t % 5) < 3), ((t % 5) == 0), (t == 0)};
            total++;
            if (obs(1) !== exp) begin
                bad++;
                $display("FAIL ratio5 cyc=%0d: clk/tick/ack=%b want %b", t, obs(1), exp);
            end
        end
        set_ch(1, 1'b0, 5);
        step();
        total++;
        if (obs(1) !== 3'b100) begin
            bad++;
            $display("FAIL ratio5_to_bypass: clk/tick/ack=%b want 100", obs(1));
        end
    endtask

    task automatic test_ratio_change();
        logic [2:0] exp;
        int         ph;
        int         r;
        set_ch(0, 1'b1, 4);
        for (int t = 0; t < 16; t++) begin
            step();
            if (t < 4) begin
                ph = t;
                r  = 4;
            end else begin
                ph = (t - 4) % 6;
                r  = 6;
            end
            exp = {(ph < (r + 1) / 2), (ph == 0), (t == 0 || t == 4)};
            total++;
            if (obs(0) !== exp) begin
                bad++;
                $display("FAIL ratio_change cyc=%0d: clk/tick/ack=%b want %b", t, obs(0), exp);
            end
            if (t == 1) set_ch(0, 1'b1, 6);
            if (t == 15) set_ch(0, 1'b0, 6);
        end
        step();
        total++;
        if (obs(0) !== 3'b100) begin
            bad++;
            $display("FAIL ratio_change_to_bypass: clk/tick/ack=%b want 100", obs(0));
        end
    endtask

    task automatic test_enable_drop();
        logic [2:0] exp;
        set_ch(2, 1'b1, 6);
        for (int t = 0; t < 6; t++) begin
            step();
            exp = {(t < 3), (t == 0), (t == 0)};
            total++;
            if (obs(2) !== exp) begin
                bad++;
                $display("FAIL enable_drop cyc=%0d: clk/tick/ack=%b want %b", t, obs(2), exp);
            end
            if (t == 1) set_ch(2, 1'b0, 6);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (obs(2) !== 3'b100) begin
                bad++;
                $display("FAIL enable_drop_bypass_hi k=%0d: clk/tick/ack=%b want 100", k, obs(2));
            end
            @(negedge i_ref_clk);
            #1;
            total++;
            if (bus.o_div_clk[2] !== 1'b0) begin
                bad++;
                $display("FAIL enable_drop_bypass_lo k=%0d: div_clk2=%b want 0", k, bus.o_div_clk[2]);
            end
        end
    endtask

    task automatic test_ratio_small();
        for (int rv = 0; rv < 2; rv++) begin
            set_ch(3, 1'b1, rv);
            for (int k = 0; k < 5; k++) begin
                step();
                total++;
                if (obs(3) !== 3'b100) begin
                    bad++;
                    $display("FAIL ratio_small r=%0d k=%0d: clk/tick/ack=%b want 100", rv, k, obs(3));
                end
            end
        end
        set_ch(3, 1'b0, 0);
    endtask

    task automatic test_ratio_max();
        logic [2:0] exp;
        set_ch(3, 1'b1, 255);
        for (int t = 0; t < 255; t++) begin
            step();
            exp = {(t < 128), (t == 0), (t == 0)};
            total++;
            if (obs(3) !== exp) begin
                bad++;
                $display("FAIL ratio_max cyc=%0d: clk/tick/ack=%b want %b", t, obs(3), exp);
            end
            if (t == 100) set_ch(3, 1'b0, 255);
        end
        step();
        total++;
        if (obs(3) !== 3'b100) begin
            bad++;
            $display("FAIL ratio_max_to_bypass: clk/tick/ack=%b want 100", obs(3));
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] exp0;
        logic [2:0] exp1;
        set_ch(0, 1'b1, 8);
        set_ch(1, 1'b1, 5);
        for (int t = 0; t < 3; t++) begin
            step();
            exp0 = {(t < 4), (t == 0), (t == 0)};
            exp1 = {(t < 3), (t == 0), (t == 0)};
            total++;
            if (obs(0) !== exp0 || obs(1) !== exp1) begin
                bad++;
                $display("FAIL pre_reset cyc=%0d: ch0=%b want %b ch1=%b want %b", t, obs(0), exp0, obs(1), exp1);
            end
        end
        i_rst = 1'b0;
        #1;
        total++;
        if (bus.o_tick !== 4'b0000 || bus.o_ratio_ack !== 4'b0000 || bus.o_div_clk !== 4'b1111) begin
            bad++;
            $display("FAIL mid_reset_now: clk=%b tick=%b ack=%b want 1111/0000/0000",
                     bus.o_div_clk, bus.o_tick, bus.o_ratio_ack);
        end
        @(negedge i_ref_clk);
        #1;
        total++;
        if (bus.o_div_clk !== 4'b0000) begin
            bad++;
            $display("FAIL mid_reset_bypass_lo: div_clk=%b want 0000", bus.o_div_clk);
        end
        set_ch(0, 1'b1, 3);
        step();
        i_rst = 1'b1;
        for (int t = 0; t < 15; t++) begin
            step();
            exp0 = {((t % 3) < 2), ((t % 3) == 0), (t == 0)};
            exp1 = {((t % 5) < 3), ((t % 5) == 0), (t == 0)};
            total++;
            if (obs(0) !== exp0) begin
                bad++;
                $display("FAIL post_reset_ch0 cyc=%0d: clk/tick/ack=%b want %b", t, obs(0), exp0);
            end
            total++;
            if (obs(1) !== exp1) begin
                bad++;
                $display("FAIL post_reset_ch1 cyc=%0d: clk/tick/ack=%b want %b", t, obs(1), exp1);
            end
            total++;
            if (obs(2) !== 3'b100 || obs(3) !== 3'b100) begin
                bad++;
                $display("FAIL post_reset_idle cyc=%0d: ch2=%b ch3=%b want 100/100", t, obs(2), obs(3));
            end
        end
        set_ch(0, 1'b0, 3);
        set_ch(1, 1'b0, 5);
        step();
        total++;
        if (obs(0) !== 3'b100 || obs(1) !== 3'b100) begin
            bad++;
            $display("FAIL post_reset_to_bypass: ch0=%b ch1=%b want 100/100", obs(0), obs(1));
        end
    endtask

    initial begin
        test_reset();
        test_ratio4();
        test_ratio5();
        test_ratio_change();
        test_enable_drop();
        test_ratio_small();
        test_ratio_max();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/multi_clock_div.md
MULTI_CLOCK_DIV -- requirements
Module: multi_clock_div

Interface
REQ-001 SHALL provide parameter RATIO_WD, default 8, giving the width of each channel's division ratio.
REQ-002 SHALL provide parameter N_CH, default 4, giving the number of independent divider channels.
REQ-003 SHALL provide i_ref_clk  input  1  reference clock; all state is clocked on its rising edge.
REQ-004 SHALL provide i_rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL provide i_clk_en  input  N_CH  per-channel divider enable.
REQ-006 SHALL provide i_div_ratio  input  N_CH*RATIO_WD  requested ratio per channel; channel c occupies bits [c*RATIO_WD +: RATIO_WD].
REQ-007 SHALL provide o_div_clk  output  N_CH  divided clock per channel.
REQ-008 SHALL provide o_tick  output  N_CH  registered one-ref-cycle pulse, asserted in the first ref cycle of each divided period.
REQ-009 SHALL provide o_ratio_ack  output  N_CH  registered one-ref-cycle pulse, asserted when a new ratio is adopted.

Function
REQ-010 SHALL keep the following per-channel state, independent of all other channels: active ratio R (RATIO_WD bits), phase counter (RATIO_WD bits), registered divided clock q, and state in {IDLE, RUN}.
REQ-011 SHALL leave the channel in IDLE while i_clk_en[c]=0 or the sampled ratio is below 2; o_div_clk[c] = i_ref_clk (bypass), q=0, counter=0, o_tick[c]=0.
REQ-012 SHALL move IDLE->RUN on the first rising edge at which i_clk_en[c]=1 and i_div_ratio[c]>=2, and in that same edge SHALL:
  - load R
  - set q=1 and counter=0
  - pulse o_ratio_ack[c] and o_tick[c] in the following ref cycle
REQ-013 SHALL, in RUN, drive q high for ceil(R/2) ref cycles and then low for floor(R/2) ref cycles, giving period R with exact 50% duty for even R; o_div_clk[c]=q.
REQ-014 SHALL define the period boundary as the rising edge at which the counter equals R-1; at that edge the counter wraps to 0.
REQ-015 SHALL sample i_div_ratio[c] and i_clk_en[c] only at the period boundary; changes mid-period SHALL NOT alter the current period (glitch-free).
REQ-016 SHALL, at a boundary with enable=1 and new ratio>=2:
  - load the new ratio into R and start the next period with q=1
  - pulse o_ratio_ack[c] only if the new ratio differs from the old R
REQ-017 SHALL, at a boundary with enable=0 or new ratio<2, return the channel to IDLE with q=0, switching to bypass only after the low phase has completed.
REQ-018 SHALL compute ceil(R/2) without overflow for R = 2^RATIO_WD - 1.
REQ-019 SHALL assert o_tick[c] exactly once per divided period while in RUN.
REQ-020 SHALL perform no cross-channel interaction; simultaneous events on different channels SHALL be handled independently in the same cycle.

Reset
REQ-021 SHALL, while i_rst=0, force every channel to IDLE with:
  - q=0, counter=0, R=0
  - o_tick=0, o_ratio_ack=0
  - o_div_clk=i_ref_clk (bypass)
REQ-022 SHALL take effect immediately on assertion, including mid-period; after release, the channel SHALL behave as in REQ-012 from the first rising edge.

Verification
REQ-023 SHALL cover: ch0 enabled, ratio=4 -> o_div_clk[0] high 2 / low 2 ref cycles, o_tick every 4 cycles, a single o_ratio_ack.
REQ-024 SHALL cover: ch1 ratio=5 -> high 3 / low 2 cycles, period 5, repeated for 10 periods.
REQ-025 SHALL cover: ratio changed 4->6 mid-period -> current 4-cycle period completes unaltered, then 3/3 periods, o_ratio_ack at the boundary.
REQ-026 SHALL cover: i_clk_en dropped mid-high-phase with ratio=6 -> period finishes (3 high / 3 low), then bypass; no runt pulse.
REQ-027 SHALL cover: ratio=0 and ratio=1 with enable=1 -> permanent bypass, o_tick=0, o_ratio_ack=0.
REQ-028 SHALL cover: i_rst asserted at counter=2 with ratio=8 -> all outputs at reset values at once; after release, ratio=3 -> 2/1 periods, with the other channels independent throughout.
